// File: rtl/argmax_pkg.sv
// Shared types and constants for the streaming argmax block.
package argmax_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int N_DEFAULT         = 10;
  localparam int DATA_BITS_DEFAULT = 18;
  localparam int IN_WORD_DEFAULT   = 29;
  localparam int RESULT_OFFSET     = 8;
  localparam int IDX_BITS          = RESULT_OFFSET;
  localparam int OUT_WORD          = 32;

endpackage

// File: rtl/argmax_compare.sv
// Signed strict-greater compare selecting the running maximum and its index.
module argmax_compare
  import argmax_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                        i_first,
  input  logic signed [DATA_BITS-1:0] i_score,
  input  logic        [IDX_BITS-1:0]  i_idx,
  input  logic signed [DATA_BITS-1:0] i_max_val,
  input  logic        [IDX_BITS-1:0]  i_max_idx,
  output logic signed [DATA_BITS-1:0] o_max_val,
  output logic        [IDX_BITS-1:0]  o_max_idx
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    o_max_val = i_max_val;
    o_max_idx = i_max_idx;
    if (i_first) begin
      o_max_val = i_score;
      o_max_idx = '0;
    end else if (i_score > i_max_val) begin
      // Strictly greater only: ties keep the earlier index.
      o_max_val = i_score;
      o_max_idx = i_idx;
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over N serialized signed scores per frame.
// Define ARGMAX_SCORE_EN to also report the winning score in out_data[31:8].
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int IN_WORD   = IN_WORD_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WORD-1:0]  in_data,
  input  logic                in_valid,
  output logic                upstream_stall,
  output logic [OUT_WORD-1:0] out_data,
  output logic                out_valid,
  input  logic                downstream_stall
);

  state_t                       r_state;
  logic        [IDX_BITS-1:0]   r_idx;
  logic        [IDX_BITS-1:0]   r_max_idx;
  logic signed [DATA_BITS-1:0]  r_max_val;

  logic signed [DATA_BITS-1:0]  w_score;
  logic signed [DATA_BITS-1:0]  w_next_val;
  logic        [IDX_BITS-1:0]   w_next_idx;
  logic                         w_in_accept;
  logic                         w_out_accept;
  logic                         w_last;
  logic                         w_unused;

  assign w_score      = in_data[DATA_BITS-1:0];
  assign w_unused     = ^in_data[IN_WORD-1:DATA_BITS];
  assign w_in_accept  = in_valid && !upstream_stall;
  assign w_out_accept = out_valid && !downstream_stall;
  assign w_last       = (r_idx == IDX_BITS'(N - 1));

  argmax_compare #(
    .DATA_BITS (DATA_BITS)
  ) u_compare (
    .i_first   (r_idx == '0),
    .i_score   (w_score),
    .i_idx     (r_idx),
    .i_max_val (r_max_val),
    .i_max_idx (r_max_idx),
    .o_max_val (w_next_val),
    .o_max_idx (w_next_idx)
  );

  // Handshake outputs are decoded straight from the state register.
  assign upstream_stall = (r_state == HOLD);
  assign out_valid      = (r_state == HOLD);

`ifdef ARGMAX_SCORE_EN
  assign out_data = {{(OUT_WORD - RESULT_OFFSET - DATA_BITS){r_max_val[DATA_BITS-1]}},
                     r_max_val, r_max_idx};
`else
  assign out_data = {{(OUT_WORD - IDX_BITS){1'b0}}, r_max_idx};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ACCUM;
      r_idx     <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_in_accept) begin
            r_max_val <= w_next_val;
            r_max_idx <= w_next_idx;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= HOLD;
            end else begin
              r_idx   <= r_idx + IDX_BITS'(1);
            end
          end
        end
        HOLD: begin
          if (w_out_accept) r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/argmax_stream.md
ARGMAX_STREAM -- requirements
Module: argmax_stream

Interface
- REQ-001: Parameter N, 10, number of serialized class scores per frame (1..255).
- REQ-002: Parameter DATA_BITS, 18, signed score width carried in the low bits of each input word.
- REQ-003: Parameter IN_WORD, 29, input word width.
- REQ-004: clock  input  1  clock; all state changes on posedge clock.
- REQ-005: reset  input  1  reset, synchronous, active-high.
- REQ-006: in_data  input  IN_WORD  serialized score; bits [DATA_BITS-1:0] are a two's-complement score; upper bits ignored.
- REQ-007: in_valid  input  1  in_data holds a score this cycle.
- REQ-008: upstream_stall  output  1  high = block refuses input this cycle.
- REQ-009: out_data  output  32  result word.
- REQ-010: out_valid  output  1  out_data holds a result.
- REQ-011: downstream_stall  input  1  high = consumer refuses out_data this cycle.

Function
- REQ-012: Input accept = in_valid && !upstream_stall; output accept = out_valid && !downstream_stall.
- REQ-013: Two states: ACCUM (collect scores) and HOLD (present result); reset state ACCUM.
- REQ-014: In ACCUM, upstream_stall SHALL be 0 and out_valid 0; in HOLD, upstream_stall SHALL be 1 and out_valid 1.
- REQ-015: A counter idx (0..N-1) SHALL count accepted scores within a frame; it increments on each input accept and returns to 0 after the Nth.
- REQ-016: At idx==0 the accepted score SHALL unconditionally load max_val and set max_idx=0.
- REQ-017: At idx>0 the score SHALL replace max_val/max_idx only if signed-strictly-greater than max_val (ties keep the lower index).
- REQ-018: The accept at idx==N-1 SHALL include its own comparison, then move to HOLD; out_valid SHALL rise the cycle after that accept (latency 1).
- REQ-019: out_data[7:0] SHALL be the final max_idx zero-extended; other bits per REQ-027/028.
- REQ-020: out_data and out_valid SHALL be stable while out_valid && downstream_stall.
- REQ-021: On output accept the block SHALL return to ACCUM the next cycle; no input is accepted in the output-accept cycle (minimum frame period N+1 cycles).
- REQ-022: in_valid low in ACCUM SHALL leave idx, max_val and max_idx unchanged (gaps allowed mid-frame).
- REQ-023: N==1 SHALL yield max_idx 0 after each single accepted word.

Reset
- REQ-024: reset SHALL force state ACCUM, idx 0, max_val 0, max_idx 0, out_valid 0, out_data 0, upstream_stall 0 on the next edge.
- REQ-025: reset mid-frame or during HOLD SHALL discard the partial frame or pending result; no out_valid pulse follows.
- REQ-026: reset SHALL take priority over simultaneous input or output accepts.

Configuration
- REQ-027: With ARGMAX_SCORE_EN defined, out_data[8+DATA_BITS-1:8] SHALL carry max_val and the remaining upper bits SHALL be its sign extension.
- REQ-028: Without ARGMAX_SCORE_EN, out_data[31:8] SHALL be 0 and no score is registered for output.

Structure
- REQ-029: Package argmax_pkg SHALL hold the state enum typedef (ACCUM, HOLD), default N/DATA_BITS/IN_WORD constants, and the result-field offset (8).
- REQ-030: One sub-module argmax_compare SHALL perform the signed strict-greater compare and select the next max_val/max_idx; everything else stays in argmax_stream.

Verification
- REQ-031: N=10, scores 0,5,-3,7,7,2,1,0,-8,6 back-to-back, no stall -> out_valid one cycle after 10th accept, out_data[7:0]=3; with ARGMAX_SCORE_EN out_data[25:8]=7.
- REQ-032: N=10, all scores -100 (0x3FF9C) -> out_data[7:0]=0; with ARGMAX_SCORE_EN out_data=0xFFFF9C00.
- REQ-033: Result pending, downstream_stall high 5 cycles -> out_data/out_valid constant, upstream_stall 1 throughout; release -> ACCUM next cycle, a new 10-word frame yields a correct result.
- REQ-034: in_valid toggled every other cycle, max at index 9 (score 0x1FFFF) -> out_data[7:0]=9.
- REQ-035: reset asserted after 4 accepted words, then full frame with max at index 2 -> exactly one result, out_data[7:0]=2.
- REQ-036: Input upper bits [28:18] randomized -> results identical to same frame with upper bits zero.
